// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall indices, stall masks and FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_MASK_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_MASK_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MASK_MEM = 6'b011111;

  // Front-end hold applied while a redirect is outstanding
  localparam logic [STALL_W-1:0] STALL_FETCH_HOLD = 6'b000011;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_stall_arb.sv
// rtl/pipe_stall_arb.sv - combinational priority encoder for stage stall requests (MEM > ID > IF)
module pipe_stall_arb
  import pipe_ctrl_pkg::*;
(
  input  logic               if_stallreq,
  input  logic               id_stallreq,
  input  logic               mem_stallreq,
  output logic [STALL_W-1:0] stall_req
);

  always_comb begin
    stall_req = STALL_NONE;
    if (mem_stallreq) begin
      stall_req = STALL_MASK_MEM;
    end else if (id_stallreq) begin
      // EX keeps advancing so ID_EX takes a bubble
      stall_req = STALL_MASK_ID;
    end else if (if_stallreq) begin
      stall_req = STALL_MASK_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, branch redirect handshake and front-end flush
// Optional PIPE_PERF_CNT_EN adds stall-cycle and flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stallreq,
  input  logic               id_stallreq,
  input  logic               mem_stallreq,
  input  logic               ex_b_flag,
  input  logic [ADDR_W-1:0]  ex_b_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  input  logic               redirect_ack,
  output logic               busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flushes
`endif
);

  pipe_state_e        state_q;
  pipe_state_e        state_d;
  logic [STALL_W-1:0] stall_req;
  logic               capture;

  pipe_stall_arb u_stall_arb (
    .if_stallreq  (if_stallreq),
    .id_stallreq  (id_stallreq),
    .mem_stallreq (mem_stallreq),
    .stall_req    (stall_req)
  );

  assign busy  = (state_q == ST_REDIRECT);
  assign stall = stall_req | (busy ? STALL_FETCH_HOLD : STALL_NONE);

  // A branch is only taken over when EX is advancing; otherwise EX re-presents it
  assign capture = (state_q == ST_RUN) && ex_b_flag && !stall[STALL_EX];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (capture) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ack) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q <= state_d;
      flush   <= capture;
      if (capture) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= ex_b_target;
      end else if ((state_q == ST_REDIRECT) && redirect_ack) begin
        redirect_valid <= 1'b0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= ZERO_WORD;
      perf_flushes      <= ZERO_WORD;
    end else begin
      if (stall != STALL_NONE) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (flush) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Merges stall requests from IF, ID and MEM into the stall vector consumed by every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Captures taken branches/jumps resolved in EX, drives the PC redirect with a valid/ack handshake to the fetch stage, and pulses a front-end flush.
- Acts as the producer side of the stall/branch interface that the inter-stage registers consume.

Parameters:
ADDR_W, 32, width of instruction address / redirect target
STALL_W, 6, stall vector width; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low
if_stallreq  in  1  fetch waiting on instruction memory
id_stallreq  in  1  load-use hazard detected in ID
mem_stallreq  in  1  data memory busy
ex_b_flag  in  1  branch/jump taken, resolved in EX this cycle
ex_b_target  in  ADDR_W  target address for ex_b_flag
stall  out  STALL_W  stall vector; bit k=1 holds stage k
flush  out  1  one-cycle pulse; IF_ID and PC-side fetch discard in-flight instruction
redirect_valid  out  1  redirect request to PC register
redirect_pc  out  ADDR_W  redirect target
redirect_ack  in  1  PC register accepted redirect_pc this cycle
busy  out  1  high while redirect pending

Behaviour:
- Reset (rst low, async): stall=0, flush=0, redirect_valid=0, redirect_pc=0, busy=0, FSM=RUN.
- Stall vector, combinational, priority MEM > ID > IF:
  - mem_stallreq: stall=6'b011111
  - else id_stallreq: 6'b000111, so ID_EX inserts a bubble (stall[2]=1, stall[3]=0)
  - else if_stallreq: 6'b000011
  - else 0
- In REDIRECT state, stall[1:0] are additionally forced to 1 (OR'd) so fetch does not advance on the wrong path.
- Branch capture: ex_b_flag sampled only when stall[3]=0 (EX advancing). On capture: redirect_pc<=ex_b_target, redirect_valid<=1, flush pulses 1 for exactly the next cycle, FSM RUN->REDIRECT.
- ex_b_flag while stall[3]=1: ignored that cycle; EX holds and re-presents it.
- REDIRECT: redirect_valid and redirect_pc held stable until redirect_ack.
  - On ack: redirect_valid<=0 next edge, FSM->RUN.
  - ack in the same cycle redirect_valid rises is legal; valid then lasts exactly one cycle.
- ex_b_flag in REDIRECT is impossible by construction (EX holds a bubble). If it occurs anyway, ignore it; assertion-worthy.
- redirect_ack while redirect_valid=0: ignored.
- busy = (FSM==REDIRECT).
- Latency: ex_b_flag to redirect_valid/flush is 1 cycle; minimum branch penalty is 2 cycles.
- Reset asserted mid-REDIRECT: pending redirect dropped, all outputs return to reset values immediately.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with stall!=0) and perf_flushes[31:0] (flush pulses). Both are free-running, wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/header (Defines.vh): stall bit indices, STALL_W, the three stall masks, FSM state encodings RUN/REDIRECT, ZeroWord.
- Sub-module: pipe_stall_arb, the combinational priority encoder producing the stall vector.
- The top keeps the FSM, redirect registers and optional counters.

Test Plan:
1. Reset release, all requests low -> stall=0, flush=0, redirect_valid=0 for 10 cycles.
2. id_stallreq=1 for 2 cycles -> stall=6'b000111 both cycles, then 0; with PIPE_PERF_CNT_EN, perf_stall_cycles=2.
3. ex_b_flag=1, ex_b_target=32'h0000_0100, ack held low 3 cycles -> next cycle flush=1 (one cycle) and redirect_valid=1 with redirect_pc=0x100 held 4 cycles; stall[1:0]=2'b11 throughout.
4. mem_stallreq=1 and ex_b_flag=1 in the same cycle -> stall=6'b011111, no flush, no redirect. Drop mem_stallreq next cycle with ex_b_flag still 1 -> capture, flush pulse the following cycle.
5. ex_b_flag captured and redirect_ack=1 in the first valid cycle -> redirect_valid high exactly 1 cycle, busy back to 0 next cycle.
6. rst driven low asynchronously mid-clock during REDIRECT -> redirect_valid, flush and busy go to 0 without a clock edge; after release, no stale redirect.
